// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchronizer plus per-bit stability filter for
// raw board switches, with a sticky change/overrun handshake toward the CPU.
// Optional macro SWITCH_EDGE_EN enables per-bit sticky 0->1 capture on `rise`;
// when undefined `rise` is tied to 0 and no capture logic exists.

// One switch bit: synchronize, then accept a new level only after it has
// persisted for DEBOUNCE consecutive synchronized cycles.
module debounce_lane #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic upd
);
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE - 1);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       lvl_q, lvl_d;
    logic [7:0] cnt_q, cnt_d;

    // Next-state: any return to the accepted level discards the count.
    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        upd   = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CNT_MAX) begin
            lvl_d = s2_q;
            cnt_d = 8'd0;
            upd   = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Lane state registers; reset clears everything without signalling an update.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = lvl_q;
endmodule

module switch_debouncer #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] swiches,
    output logic             change,
    output logic             overrun,
    input  logic             change_ack,
    output logic [WIDTH-1:0] rise
);
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    logic [WIDTH-1:0] upd;
    logic             upd_any;
    state_t           state_q, state_d;
    logic             ovr_q, ovr_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            debounce_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
                .clk   (clk),
                .clr   (clr),
                .raw   (sw_raw[gi]),
                .level (swiches[gi]),
                .upd   (upd[gi])
            );
        end
    endgenerate

    assign upd_any = |upd;

    // Handshake next-state: a new update always wins over an ack; an ack
    // arriving with an update consumes the older event, so overrun clears.
    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (upd_any) state_d = PENDING;
            end
            PENDING: begin
                if (upd_any) begin
                    state_d = PENDING;
                    ovr_d   = !change_ack;
                end else if (change_ack) begin
                    state_d = IDLE;
                    ovr_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ovr_d   = 1'b0;
            end
        endcase
    end

    // Handshake state registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
        end
    end

    assign change  = (state_q == PENDING);
    assign overrun = ovr_q;

`ifdef SWITCH_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;

    // Sticky rising-edge capture: ack clears, a same-cycle rise re-sets.
    always_comb begin
        rise_d = change_ack ? '0 : rise_q;
        rise_d = rise_d | (upd & ~swiches);
    end

    // Rise capture register.
    always_ff @(posedge clk) begin
        if (clr) rise_q <= '0;
        else     rise_q <= rise_d;
    end

    assign rise = rise_q;
`else
    assign rise = '0;
`endif
endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-conditioning stage that sits directly upstream of the `cpu` block: it takes the raw, asynchronous, bouncing board switches and produces the clean `swiches` vector the CPU reads. Each bit is synchronized into `clk`, then filtered by a per-bit stability counter. A sticky change-event flag with an acknowledge handshake lets the CPU, or a polling controller, detect that a new switch value has been accepted.

## Interface
Parameters:
- `WIDTH`, 8: number of switch bits.
- `DEBOUNCE`, 4: consecutive synchronized cycles a new level must persist before it is accepted. Legal range 1..255. Per-bit counter is 8 bits.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `clr`  in  1  reset, synchronous, active-high.
- `sw_raw`  in  WIDTH  raw asynchronous switch levels.
- `swiches`  out  WIDTH  debounced switch vector, fed to `cpu.swiches`.
- `change`  out  1  sticky flag: at least one `swiches` bit updated since the last ack.
- `overrun`  out  1  sticky flag: an update occurred while `change` was already set.
- `change_ack`  in  1  clears `change`, `overrun` and `rise`.
- `rise`  out  WIDTH  per-bit sticky 0→1 capture (see Configuration).

## Operation
- Synchronizer per bit: `s1 <= sw_raw`, `s2 <= s1`. Both reset to 0.
- Filter per bit i, evaluated every cycle:
  - If `s2[i] == swiches[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE-1`: `swiches[i] <= s2[i]` and `cnt[i] <= 0`. This is an "update" of bit i.
  - Else: `cnt[i] <= cnt[i]+1`.
- Any return of `s2[i]` to the current `swiches[i]` before acceptance discards the accumulated count. Pulses shorter than `DEBOUNCE` synchronized cycles never propagate.
- Bits are independent. Several bits may update in the same cycle.
- Event flags, handshake with two states, IDLE (`change`=0) and PENDING (`change`=1):
  - In IDLE, any update → PENDING.
  - In PENDING, `change_ack`=1 with no update → IDLE.
  - In PENDING, an update with no ack → stays PENDING and sets `overrun`=1.
  - Update and `change_ack` in the same cycle: the set wins. The state is PENDING and `overrun` is cleared, because the ack consumed the previous event.
  - `change_ack` in IDLE has no effect.
- Reset (`clr`=1 at a rising edge), including mid-count or while PENDING: `s1`, `s2`, `cnt`, `swiches`, `change`, `overrun` and `rise` all go to 0. No update event is generated by reset.

## Timing
- Reset values: `swiches`=0, `change`=0, `overrun`=0, `rise`=0.
- Latency from a stable `sw_raw[i]` change to `swiches[i]` toggling:
  - The change is set up before edge E1.
  - `swiches[i]` changes after edge E(2+DEBOUNCE).
  - With `DEBOUNCE`=4 this is 6 edges.
- `change` asserts on the same edge that `swiches` updates.
- `change` deasserts on the edge that samples `change_ack`=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro `SWITCH_EDGE_EN`.
- Defined:
  - On any update where `swiches[i]` goes 0→1, `rise[i]` is set.
  - `rise` is cleared by `change_ack`.
  - A rise and an ack in the same cycle leave that bit set, because the set wins.
- Undefined:
  - The `rise` port still exists and is tied to 0.
  - No capture logic is synthesized.

## Test plan
- Reset: hold `clr`=1 for 2 cycles with `sw_raw`=8'hFF. Required: `swiches`=8'h00, `change`=0, `rise`=8'h00.
- Clean change: release `clr`, set `sw_raw`=8'h48 and hold. Required:
  - `swiches`=8'h48 and `change`=1 exactly 6 edges later (`DEBOUNCE`=4).
  - `rise`=8'h48 with `SWITCH_EDGE_EN` defined, 8'h00 without it.
- Bounce rejection: starting from `swiches`=8'h48, toggle `sw_raw[0]` high for 3 cycles then low, repeated 4 times. Required: `swiches` stays 8'h48 and `change` stays unchanged.
- Handshake and overrun:
  - Sequence: 8'h48 accepted, no ack, then `sw_raw`=8'h49 accepted.
  - Required after the second update: `change`=1, `overrun`=1.
  - Pulse `change_ack` for 1 cycle. Required: `change`=0, `overrun`=0, `rise`=0 on the next cycle.
- Simultaneous update and ack: assert `change_ack` on the exact edge that `swiches` goes 8'h49→8'hC9. Required: `change`=1, `overrun`=0, and `rise[7]`=1 when `SWITCH_EDGE_EN` is defined.
- Reset mid-count: drive `sw_raw`=8'h0F, assert `clr` 3 edges later for 1 cycle, then keep `sw_raw`=8'h0F. Required: `swiches`=0 right after reset, then 8'h0F exactly 6 edges after `clr` falls.
